// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the clk domain; all four SPI modes, one-entry TX holding buffer,
// RX word output with a single-cycle valid strobe.
module spi_slave_sync #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int unsigned    CNT_W    = $clog2(DATA_WIDTH);
    localparam logic           IDLE_LVL = 1'(CPOL);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic                   sclk_s, cs_s, mosi_s, sclk_d;
    logic                   lead_c, trail_c, sample_edge_c, shift_edge_c;
    logic                   load_c, sample_c, shift_c, word_done_c, abort_c, accept_c;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_shreg, tx_shreg, hold_q, load_word_c, rx_word_c;
    logic                   hold_full;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    // Input synchronisers plus one extra sclk tap for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q <= {SYNC_STAGES{IDLE_LVL}};
            cs_q   <= '1;
            mosi_q <= '0;
            sclk_d <= IDLE_LVL;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_s;
        end
    end

    assign sclk_s        = sclk_q[SYNC_STAGES-1];
    assign cs_s          = cs_q[SYNC_STAGES-1];
    assign mosi_s        = mosi_q[SYNC_STAGES-1];
    assign lead_c        = (sclk_d == IDLE_LVL) && (sclk_s != IDLE_LVL);
    assign trail_c       = (sclk_d != IDLE_LVL) && (sclk_s == IDLE_LVL);
    assign sample_edge_c = (CPHA == 0) ? lead_c : trail_c;
    assign shift_edge_c  = (CPHA == 0) ? trail_c : lead_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!cs_s) state_nxt = S_ACTIVE;
            S_ACTIVE: if (cs_s)  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // CPHA=0 skips the trailing edge that follows a word boundary: the new first bit is already out
    always_comb begin
        load_c      = 1'b0;
        sample_c    = 1'b0;
        shift_c     = 1'b0;
        word_done_c = 1'b0;
        abort_c     = 1'b0;
        case (state)
            S_IDLE: load_c = !cs_s;
            S_ACTIVE: begin
                if (cs_s) begin
                    abort_c = 1'b1;
                end else begin
                    sample_c    = sample_edge_c;
                    word_done_c = sample_edge_c && (bit_cnt == LAST_BIT);
                    load_c      = word_done_c;
                    shift_c     = shift_edge_c && ((CPHA != 0) || (bit_cnt != '0));
                end
            end
            default: ;
        endcase
    end

    assign accept_c    = tx_valid && !hold_full;
    assign load_word_c = hold_full ? hold_q : '0;
    assign rx_word_c   = (MSB_FIRST != 0) ? {rx_shreg[DATA_WIDTH-2:0], mosi_s}
                                          : {mosi_s, rx_shreg[DATA_WIDTH-1:1]};
    assign tx_ready    = !hold_full;
    assign busy        = (state == S_ACTIVE);
    assign miso_oe     = (state == S_ACTIVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (accept_c) begin
            hold_q    <= tx_data;
            hold_full <= 1'b1;
        end else if (load_c) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= '0;
            rx_shreg    <= '0;
            tx_shreg    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            miso        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (abort_c) begin
                bit_cnt  <= '0;
                rx_shreg <= '0;
                tx_shreg <= '0;
                miso     <= 1'b0;
            end else begin
                if (sample_c) begin
                    if (word_done_c) begin
                        rx_data  <= rx_word_c;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        rx_shreg <= '0;
                    end else begin
                        rx_shreg <= rx_word_c;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end
                end
                if (load_c) begin
                    tx_underrun <= !hold_full;
                    if (CPHA == 0) begin
                        miso     <= first_bit(load_word_c);
                        tx_shreg <= shift_out(load_word_c);
                    end else begin
                        tx_shreg <= load_word_c;
                    end
                end else if (shift_c) begin
                    miso     <= first_bit(tx_shreg);
                    tx_shreg <= shift_out(tx_shreg);
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: one 32-bit mode-0 slave plus 8-bit slaves in every mode
// and an LSB-first variant, all sharing one bit-banged master.
`timescale 1ns/1ps
module tb_spi_slave_sync;
    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic [5:0]  cs_v = '1;
    logic [5:0]  txv_v = '0;
    logic [31:0] tx32 = '0;
    logic [7:0]  tx8 = '0;
    wire  [5:0]  miso_v, oe_v, txr_v, rxv_v, uf_v, busy_v;
    wire  [31:0] rxd0;
    wire  [5:1][7:0] rxd8;
    int          checks = 0;
    int          failures = 0;
    int          rxv_cnt [6];
    int          uf_cnt [6];

    always #5 clk = ~clk;

    spi_slave_sync #(.DATA_WIDTH(32), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .cs(cs_v[0]), .sclk(sck), .mosi(mosi),
        .miso(miso_v[0]), .miso_oe(oe_v[0]), .tx_data(tx32), .tx_valid(txv_v[0]),
        .tx_ready(txr_v[0]), .rx_data(rxd0), .rx_valid(rxv_v[0]),
        .tx_underrun(uf_v[0]), .busy(busy_v[0]));

    // Index 1..4: modes 0..3 (CPOL,CPHA), index 5: mode 0 LSB first
    for (genvar g = 1; g <= 5; g++) begin : g_m8
        localparam int unsigned P_CPOL = (g == 3 || g == 4) ? 1 : 0;
        localparam int unsigned P_CPHA = (g == 2 || g == 4) ? 1 : 0;
        localparam int unsigned P_MSB  = (g == 5) ? 0 : 1;
        wire sclk_g = (P_CPOL != 0) ? ~sck : sck;
        spi_slave_sync #(.DATA_WIDTH(8), .CPOL(P_CPOL), .CPHA(P_CPHA), .MSB_FIRST(P_MSB),
                         .SYNC_STAGES(2)) u_dut (
            .clk(clk), .rst(rst), .cs(cs_v[g]), .sclk(sclk_g), .mosi(mosi),
            .miso(miso_v[g]), .miso_oe(oe_v[g]), .tx_data(tx8), .tx_valid(txv_v[g]),
            .tx_ready(txr_v[g]), .rx_data(rxd8[g]), .rx_valid(rxv_v[g]),
            .tx_underrun(uf_v[g]), .busy(busy_v[g]));
    end

    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (rxv_v[i]) rxv_cnt[i] <= rxv_cnt[i] + 1;
            if (uf_v[i])  uf_cnt[i]  <= uf_cnt[i] + 1;
        end
    end

    task automatic push(input int k, input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        while (!txr_v[k] && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txr_v[k] !== 1'b1) begin
            failures++;
            $display("FAIL push_wait k=%0d: tx_ready=%b required 1", k, txr_v[k]);
        end else begin
            if (k == 0) tx32 = w; else tx8 = w[7:0];
            txv_v[k] = 1'b1;
            @(negedge clk);
            txv_v[k] = 1'b0;
        end
    endtask

    task automatic cs_on(input int k);
        @(negedge clk);
        cs_v[k] = 1'b0;
    endtask

    task automatic cs_off(input int k);
        #HALF;
        cs_v[k] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Master side: drives mosi / captures miso in the line order of slave k
    task automatic xfer_word(input int k, input int nbits, input logic [31:0] mo,
                             output logic [31:0] mi);
        bit cpha = (k == 2 || k == 4);
        bit msbf = (k != 5);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx = msbf ? nbits - 1 - i : i;
            if (!cpha) begin
                mosi = mo[idx];
                #HALF;
                mi[idx] = miso_v[k];
                sck = 1'b1;
                #HALF;
                sck = 1'b0;
            end else begin
                #HALF;
                sck = 1'b1;
                mosi = mo[idx];
                #HALF;
                mi[idx] = miso_v[k];
                sck = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({miso_v[0], oe_v[0], txr_v[0], rxv_v[0], uf_v[0], busy_v[0]} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_flags: got %b required 001000",
                     {miso_v[0], oe_v[0], txr_v[0], rxv_v[0], uf_v[0], busy_v[0]});
        end
        checks++;
        if (rxd0 !== 32'h0) begin
            failures++;
            $display("FAIL reset_rx_data: got %h required 00000000", rxd0);
        end
        checks++;
        if (txr_v !== 6'h3F) begin
            failures++;
            $display("FAIL reset_tx_ready_all: got %b required 111111", txr_v);
        end
    endtask

    task automatic test_mode0_32();
        logic [31:0] mi;
        int r0 = rxv_cnt[0];
        int u0 = uf_cnt[0];
        push(0, 32'hA5A5_1234);
        cs_on(0);
        repeat (6) @(negedge clk);
        checks++;
        if ({busy_v[0], oe_v[0]} !== 2'b11) begin
            failures++;
            $display("FAIL m0_busy_oe: got %b required 11", {busy_v[0], oe_v[0]});
        end
        xfer_word(0, 32, 32'hDEAD_BEEF, mi);
        cs_off(0);
        checks++;
        if (mi !== 32'hA5A5_1234) begin
            failures++;
            $display("FAIL m0_miso: got %h required a5a51234", mi);
        end
        checks++;
        if (rxd0 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL m0_rx_data: got %h required deadbeef", rxd0);
        end
        checks++;
        if (rxv_cnt[0] - r0 !== 1) begin
            failures++;
            $display("FAIL m0_rx_valid_cycles: got %0d required 1", rxv_cnt[0] - r0);
        end
        checks++;
        if (uf_cnt[0] - u0 !== 1) begin
            failures++;
            $display("FAIL m0_end_underrun: got %0d required 1", uf_cnt[0] - u0);
        end
        checks++;
        if ({busy_v[0], oe_v[0], txr_v[0]} !== 3'b001) begin
            failures++;
            $display("FAIL m0_after_cs: got %b required 001", {busy_v[0], oe_v[0], txr_v[0]});
        end
    endtask

    task automatic test_modes();
        logic [7:0]  tx_w [2] = '{8'h3C, 8'h35};
        logic [7:0]  mo_w [2] = '{8'hC3, 8'h9A};
        logic [31:0] mi;
        for (int k = 1; k <= 5; k++) begin
            for (int v = 0; v < 2; v++) begin
                int r0 = rxv_cnt[k];
                push(k, {24'h0, tx_w[v]});
                cs_on(k);
                xfer_word(k, 8, {24'h0, mo_w[v]}, mi);
                cs_off(k);
                checks++;
                if (mi[7:0] !== tx_w[v]) begin
                    failures++;
                    $display("FAIL mode%0d_miso v%0d: got %h required %h", k, v, mi[7:0], tx_w[v]);
                end
                checks++;
                if (rxd8[k] !== mo_w[v]) begin
                    failures++;
                    $display("FAIL mode%0d_rx_data v%0d: got %h required %h", k, v, rxd8[k], mo_w[v]);
                end
                checks++;
                if (rxv_cnt[k] - r0 !== 1) begin
                    failures++;
                    $display("FAIL mode%0d_rx_valid v%0d: got %0d required 1", k, v, rxv_cnt[k] - r0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mo [3] = '{32'h0102_0304, 32'hCAFE_F00D, 32'h1234_5678};
        logic [31:0] ex [3] = '{32'h11, 32'h22, 32'h33};
        logic [31:0] mi;
        int r0 = rxv_cnt[0];
        int u0 = uf_cnt[0];
        push(0, 32'h11);
        fork
            begin
                push(0, 32'h22);
                push(0, 32'h33);
            end
            begin
                cs_on(0);
                for (int w = 0; w < 3; w++) begin
                    xfer_word(0, 32, mo[w], mi);
                    checks++;
                    if (mi !== ex[w]) begin
                        failures++;
                        $display("FAIL b2b_miso w%0d: got %h required %h", w, mi, ex[w]);
                    end
                    checks++;
                    if (rxd0 !== mo[w]) begin
                        failures++;
                        $display("FAIL b2b_rx_data w%0d: got %h required %h", w, rxd0, mo[w]);
                    end
                end
                cs_off(0);
            end
        join
        checks++;
        if (rxv_cnt[0] - r0 !== 3) begin
            failures++;
            $display("FAIL b2b_rx_valid_cycles: got %0d required 3", rxv_cnt[0] - r0);
        end
        checks++;
        if (uf_cnt[0] - u0 !== 1) begin
            failures++;
            $display("FAIL b2b_underrun: got %0d required 1", uf_cnt[0] - u0);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] mi;
        int u0 = uf_cnt[0];
        cs_on(0);
        repeat (10) @(negedge clk);
        checks++;
        if (uf_cnt[0] - u0 !== 1) begin
            failures++;
            $display("FAIL ur_start_pulse: got %0d required 1", uf_cnt[0] - u0);
        end
        xfer_word(0, 32, 32'h1357_9BDF, mi);
        cs_off(0);
        checks++;
        if (mi !== 32'h0) begin
            failures++;
            $display("FAIL ur_miso: got %h required 00000000", mi);
        end
        checks++;
        if (rxd0 !== 32'h1357_9BDF) begin
            failures++;
            $display("FAIL ur_rx_data: got %h required 13579bdf", rxd0);
        end
        checks++;
        if (uf_cnt[0] - u0 !== 2) begin
            failures++;
            $display("FAIL ur_total_pulses: got %0d required 2", uf_cnt[0] - u0);
        end
    endtask

    task automatic test_abort();
        logic [31:0] mi;
        int r0 = rxv_cnt[0];
        push(0, 32'hFFFF_FFFF);
        cs_on(0);
        xfer_word(0, 13, 32'h0000_1ABC, mi);
        checks++;
        if (miso_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort_miso_before: got %b required 1", miso_v[0]);
        end
        cs_off(0);
        checks++;
        if (rxv_cnt[0] - r0 !== 0) begin
            failures++;
            $display("FAIL abort_rx_valid: got %0d required 0", rxv_cnt[0] - r0);
        end
        checks++;
        if (rxd0 !== 32'h1357_9BDF) begin
            failures++;
            $display("FAIL abort_rx_held: got %h required 13579bdf", rxd0);
        end
        checks++;
        if ({miso_v[0], oe_v[0], busy_v[0], txr_v[0]} !== 4'b0001) begin
            failures++;
            $display("FAIL abort_lines: got %b required 0001",
                     {miso_v[0], oe_v[0], busy_v[0], txr_v[0]});
        end
        r0 = rxv_cnt[0];
        push(0, 32'h0F0F_5A5A);
        cs_on(0);
        xfer_word(0, 32, 32'h2468_ACE0, mi);
        cs_off(0);
        checks++;
        if (mi !== 32'h0F0F_5A5A) begin
            failures++;
            $display("FAIL abort_next_miso: got %h required 0f0f5a5a", mi);
        end
        checks++;
        if (rxd0 !== 32'h2468_ACE0 || rxv_cnt[0] - r0 !== 1) begin
            failures++;
            $display("FAIL abort_next_rx: got %h/%0d required 2468ace0/1", rxd0, rxv_cnt[0] - r0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] mi;
        push(0, 32'hAAAA_5555);
        cs_on(0);
        repeat (6) @(negedge clk);
        push(0, 32'h1234_5678);
        xfer_word(0, 5, 32'h0000_0015, mi);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({miso_v[0], oe_v[0], txr_v[0], rxv_v[0], uf_v[0], busy_v[0]} !== 6'b001000) begin
            failures++;
            $display("FAIL rstmid_flags: got %b required 001000",
                     {miso_v[0], oe_v[0], txr_v[0], rxv_v[0], uf_v[0], busy_v[0]});
        end
        checks++;
        if (rxd0 !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_rx_data: got %h required 00000000", rxd0);
        end
        cs_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({txr_v[0], busy_v[0]} !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_release: got %b required 10", {txr_v[0], busy_v[0]});
        end
        push(0, 32'hC001_D00D);
        cs_on(0);
        xfer_word(0, 32, 32'hFACE_0001, mi);
        cs_off(0);
        checks++;
        if (mi !== 32'hC001_D00D || rxd0 !== 32'hFACE_0001) begin
            failures++;
            $display("FAIL rstmid_recover: got %h/%h required c001d00d/face0001", mi, rxd0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_mode0_32();
        test_modes();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised SPI slave that runs entirely in the system clock domain: it oversamples `sclk`, `cs` and `mosi` through synchronisers and supports all four SPI modes via parameters. Words are exchanged with the fabric through a one-entry TX holding buffer (valid/ready) and an RX word output with a single-cycle valid strobe. It replaces the mode-fixed, sclk-clocked slave used as the SPI master's bench partner and on-chip peripheral endpoint.

## Interface
- `DATA_WIDTH`, 32, bits per SPI word (≥ 2)
- `CPOL`, 0, idle level of `sclk`
- `CPHA`, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- `MSB_FIRST`, 1, 1 = MSB shifted first on both lines, 0 = LSB first
- `SYNC_STAGES`, 2, synchroniser depth for `sclk`, `cs`, `mosi` (≥ 2)

- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `cs`  input  1  chip select, active-low, asynchronous to `clk`
- `sclk`  input  1  SPI clock, asynchronous to `clk`
- `mosi`  input  1  serial data in
- `miso`  output  1  serial data out
- `miso_oe`  output  1  output enable for `miso` pad; high only while synced `cs` low
- `tx_data`  input  DATA_WIDTH  next word to transmit
- `tx_valid`  input  1  `tx_data` valid
- `tx_ready`  output  1  TX holding buffer empty
- `rx_data`  output  DATA_WIDTH  last fully received word
- `rx_valid`  output  1  one-cycle strobe, `rx_data` updated
- `tx_underrun`  output  1  one-cycle strobe, word load found buffer empty
- `busy`  output  1  synced `cs` low

## Operation
- Synchronisers: `SYNC_STAGES` flops per input; edge detect compares last synced `sclk` with one extra delayed copy. Leading edge = transition away from `CPOL`; trailing = back to `CPOL`.
- Sample edge = leading if `CPHA`=0 else trailing; shift edge = the other.
- States: IDLE, ACTIVE. IDLE -> ACTIVE on synced `cs` falling; ACTIVE -> IDLE on synced `cs` rising (any state).
- Word load: on IDLE->ACTIVE and on every word boundary in ACTIVE, TX shift register takes holding buffer (buffer -> empty, `tx_ready` rises next cycle); if empty, loads all zeros and pulses `tx_underrun`.
- Holding buffer accepts `tx_data` when `tx_valid && tx_ready`; a load and an accept in the same cycle: load takes old content, new word enters buffer.
- `miso`: CPHA=0 — first bit driven in the word-load cycle, subsequent bits on shift edges. CPHA=1 — first bit driven on first leading (shift) edge; at each word boundary the next word's first bit on the next shift edge.
- RX: each sample edge shifts synced `mosi` in (order per `MSB_FIRST`), bit counter increments 0..DATA_WIDTH-1. On sample DATA_WIDTH: `rx_data` <= assembled word, `rx_valid` pulses, counter wraps to 0, word boundary (next word load) in same cycle. No backpressure; consumer must take `rx_data` before next word completes.
- `cs` rising mid-word: partial RX discarded (no `rx_valid`), counter cleared, TX shift register discarded (consumed buffer word not restored), `miso_oe` low, `miso` 0.
- Edges seen while synced `cs` high are ignored.

## Timing
- Reset values: `miso` 0, `miso_oe` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `tx_underrun` 0, `busy` 0; buffer empty, counter 0, state IDLE.
- Pin-to-action latency: SYNC_STAGES+1 `clk` cycles for `cs` edges, `sclk` edges and `miso` updates; `rx_valid` asserts SYNC_STAGES+1 cycles after the last sample edge at the pin.
- Requirement: each `sclk` high and low phase ≥ SYNC_STAGES+2 `clk` cycles; `cs` low to first `sclk` edge ≥ SYNC_STAGES+2 cycles; mosi stable across sample edge ± 1 `clk`.
- `rx_valid`, `tx_underrun` exactly one cycle high; `rx_data` held until next completed word.

## Test plan
- Mode 0, DATA_WIDTH 32: preload tx 0xA5A5_1234, master sends 0xDEAD_BEEF -> master reads 0xA5A5_1234, `rx_data`=0xDEAD_BEEF, single `rx_valid`.
- All four CPOL/CPHA combos, DATA_WIDTH 8, tx 0x3C, mosi 0xC3 -> 0x3C on miso, `rx_data`=0xC3 in every mode; MSB_FIRST=0 variant -> bit-reversed line order, same words.
- Back-to-back: cs held low for 3 words, tx 0x11,0x22,0x33 refilled on `tx_ready` -> miso 0x11,0x22,0x33; three `rx_valid` pulses.
- Underrun: no tx word at cs fall -> `tx_underrun` pulse, miso all zeros, RX still correct.
- Abort: cs rises after 13 of 32 bits -> no `rx_valid`, `miso_oe` 0; next full transfer correct.
- Async `rst` low mid-transfer -> all outputs to reset values immediately; `tx_ready` 1 after release.
